axi_lite_cmd_master: RTL and testbench
======================================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the AXI address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the AXI data width in bits; WSTRB width is DATA_WIDTH/8.
REQ-003 Clock and reset: ACLK is the clock, and ARESETN is the reset, asynchronous, active-high.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
  ACLK  in  1  clock, all logic on rising edge
  ARESETN  in  1  reset, asynchronous, active-high
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted this cycle
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  ADDR_WIDTH  target address
  cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed
  rsp_write  out  1  echo of cmd_write
  rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
  rsp_resp  out  2  captured BRESP/RRESP
  err_count  out  8  saturating count of non-OKAY responses
  AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDR_WIDTH  AXI write address
  WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  AXI write data
  BVALID/BREADY/BRESP  in/out/in  1/1/2  AXI write response
  ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDR_WIDTH  AXI read address
  RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_WIDTH/2  AXI read data

Function
REQ-005 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, and RSP, and all outputs SHALL be driven from registers, with no combinational path from any AXI input to any AXI output.
REQ-006 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-007 On accepting a write, the FSM SHALL go to WR_REQ and assert AWVALID and WVALID in the next cycle together, with AWADDR=cmd_addr, WDATA=cmd_wdata, and WSTRB all ones.
REQ-008 In WR_REQ, AWVALID and WVALID SHALL each deassert on the edge where their own handshake (VALID and READY both 1) completes, independently of each other; AWADDR, WDATA, and WSTRB SHALL stay stable while the corresponding VALID is high.
REQ-009 When both the AW and W handshakes have completed, in the same or different cycles, the FSM SHALL enter WR_RESP and assert BREADY; BREADY SHALL never be 1 before both handshakes complete.
REQ-010 In WR_RESP, on BVALID and BREADY both 1, the block SHALL capture BRESP into rsp_resp, set rsp_rdata=0 and rsp_write=1, drop BREADY, and enter RSP.
REQ-011 On accepting a read, the FSM SHALL go to RD_REQ and assert ARVALID with ARADDR=cmd_addr, holding it until ARREADY; on that handshake it SHALL drop ARVALID and enter RD_DATA with RREADY=1.
REQ-012 In RD_DATA, on RVALID and RREADY both 1, the block SHALL capture RDATA and RRESP, set rsp_write=0, drop RREADY, and enter RSP.
REQ-013 In RSP, rsp_valid SHALL be 1 and the rsp_* fields SHALL be held stable until rsp_ready=1; on that edge rsp_valid SHALL drop and the FSM SHALL return to IDLE, so that cmd_ready=1 in the following cycle.
REQ-014 err_count SHALL increment by 1 when a response with resp≠2'b00 is captured, and SHALL saturate at 8'hFF with no wrap.
REQ-015 Only one transaction SHALL be outstanding; cmd_valid while not in IDLE SHALL be ignored, with no state change.
REQ-016 Latency with a zero-wait slave (READY held 1; BVALID/RVALID asserted the cycle after the address handshake) SHALL be: command accepted at edge N, rsp_valid=1 after edge N+3.

Reset
REQ-017 While ARESETN=1, the block SHALL immediately force the FSM to IDLE and set all VALID/READY outputs to 0 except cmd_ready, which SHALL be 0 during reset and 1 after release; AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp, rsp_write, and err_count SHALL be 0, and WSTRB SHALL be all ones.
REQ-018 Reset asserted mid-transaction SHALL discard the transaction, with no response issued; after release the block SHALL accept a new command.

Verification
REQ-019 Write 0x04←0xAB with a zero-wait slave → AWADDR=0x04, WDATA=0xAB, WSTRB=1 for one cycle, then BREADY; rsp_valid with rsp_write=1, rsp_resp=0, rsp_rdata=0 at edge N+3.
REQ-020 Read 0x04 after REQ-019 (memory-model slave) → ARADDR=0x04; rsp_rdata=0xAB, rsp_resp=0, rsp_write=0.
REQ-021 Write 0x0A←0x69 with WREADY delayed 3 cycles after AWREADY → AWVALID drops after 1 cycle, WVALID is held 4 cycles, BREADY only after the W handshake; read 0x0A returns 0x69.
REQ-022 Slave returns BRESP=2'b10 twice, then RRESP=2'b11 → rsp_resp matches each time, err_count=3; preload err_count at 0xFF via 255 errors, then one more error → err_count stays 0xFF.
REQ-023 cmd_valid pulsed while in RD_DATA, and rsp_ready held 0 for 5 cycles → the second command is ignored, rsp fields are stable for 5 cycles, and cmd_ready=1 the cycle after rsp_ready.
REQ-024 ARESETN asserted while in WR_RESP → BREADY and all VALIDs drop at once, no rsp_valid appears; after release, read 0x0F completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into an AW/W/B or AR/R
// exchange and hands back a registered response with a saturating error count.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [7:0]              err_count,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    WVALID,
   input  logic                    WREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    BVALID,
   output logic                    BREADY,
   input  logic [1:0]              BRESP,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    RVALID,
   output logic                    RREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t state;
   logic   aw_done;
   logic   w_done;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign b_hs  = BVALID && BREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;

   always_ff @(posedge ACLK or posedge ARESETN) begin
      if (ARESETN) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         AWVALID   <= 1'b0;
         AWADDR    <= '0;
         WVALID    <= 1'b0;
         WDATA     <= '0;
         WSTRB     <= '1;
         BREADY    <= 1'b0;
         ARVALID   <= 1'b0;
         ARADDR    <= '0;
         RREADY    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
         err_count <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  if (cmd_write) begin
                     AWVALID <= 1'b1;
                     AWADDR  <= cmd_addr;
                     WVALID  <= 1'b1;
                     WDATA   <= cmd_wdata;
                     WSTRB   <= '1;
                     state   <= WR_REQ;
                  end else begin
                     ARVALID <= 1'b1;
                     ARADDR  <= cmd_addr;
                     state   <= RD_REQ;
                  end
               end else begin
                  // also raises cmd_ready on the first edge after reset release
                  cmd_ready <= 1'b1;
               end
            end
            WR_REQ: begin
               // AW and W retire independently; B is only opened once both have
               if (aw_hs) begin
                  AWVALID <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  WVALID <= 1'b0;
                  w_done <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  BREADY <= 1'b1;
                  state  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (b_hs) begin
                  BREADY    <= 1'b0;
                  rsp_resp  <= BRESP;
                  rsp_rdata <= '0;
                  rsp_write <= 1'b1;
                  rsp_valid <= 1'b1;
                  if (BRESP != 2'b00 && err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
                  state <= RSP;
               end
            end
            RD_REQ: begin
               if (ar_hs) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_hs) begin
                  RREADY    <= 1'b0;
                  rsp_resp  <= RRESP;
                  rsp_rdata <= RDATA;
                  rsp_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  if (RRESP != 2'b00 && err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
                  state <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: memory-model AXI-Lite slave with a
// programmable W delay and response code, a vector table and corner sequences.
module tb_axi_lite_cmd_master;

   logic       ACLK = 1'b0;
   logic       ARESETN;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_ready, rsp_write;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_resp;
   logic [7:0] err_count;
   logic       AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [7:0] AWADDR, WDATA;
   logic [0:0] WSTRB;
   logic [1:0] BRESP, RRESP;
   logic       ARVALID, ARREADY, RVALID, RREADY;
   logic [7:0] ARADDR, RDATA;

   axi_lite_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
   );

   always #5 ACLK = ~ACLK;

   // slave knobs
   logic [1:0] slv_resp = 2'b00;
   logic [3:0] wdly = 4'd0;
   logic       hold_b = 1'b0;

   logic [7:0] mem [256] = '{default: 8'h00};
   logic       aw_got, w_got, ar_got;
   logic [7:0] last_awaddr, last_wdata, last_araddr;
   logic [0:0] last_wstrb;
   logic [3:0] wcnt;

   assign AWREADY = 1'b1;
   assign ARREADY = 1'b1;
   assign WREADY  = (wcnt == wdly);

   // registered slave: responds one cycle after the request handshakes
   always @(posedge ACLK or posedge ARESETN) begin
      if (ARESETN) begin
         BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= 8'h00;
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; wcnt <= 4'd0;
         last_awaddr <= 8'h00; last_wdata <= 8'h00; last_araddr <= 8'h00; last_wstrb <= 1'b0;
      end else begin
         if (AWVALID && AWREADY) begin aw_got <= 1'b1; last_awaddr <= AWADDR; end
         if (WVALID && WREADY) begin
            w_got <= 1'b1; last_wdata <= WDATA; last_wstrb <= WSTRB; wcnt <= 4'd0;
         end else if (WVALID) wcnt <= wcnt + 4'd1;
         if (aw_got && w_got && !BVALID && !hold_b) begin
            BVALID <= 1'b1; BRESP <= slv_resp; mem[last_awaddr] <= last_wdata;
         end
         if (BVALID && BREADY) begin BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
         if (ARVALID && ARREADY) begin ar_got <= 1'b1; last_araddr <= ARADDR; end
         if (ar_got && !RVALID) begin
            RVALID <= 1'b1; RDATA <= mem[last_araddr]; RRESP <= slv_resp; ar_got <= 1'b0;
         end
         if (RVALID && RREADY) RVALID <= 1'b0;
      end
   end

   // per-transaction protocol monitor, cleared on command acceptance
   int   aw_cyc, w_cyc;
   logic bready_early;
   always @(posedge ACLK) begin
      if (cmd_valid && cmd_ready) begin
         aw_cyc <= 0; w_cyc <= 0; bready_early <= 1'b0;
      end else begin
         if (AWVALID) aw_cyc <= aw_cyc + 1;
         if (WVALID) w_cyc <= w_cyc + 1;
         if (BREADY && !(aw_got && w_got)) bready_early <= 1'b1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
      int n = 0;
      @(negedge ACLK);
      while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
      chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(posedge ACLK);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(posedge ACLK); lat++;
         @(negedge ACLK);
      end while (!rsp_valid && lat < 50);
      chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(posedge ACLK);
      #1 rsp_ready = 1'b0;
      @(negedge ACLK);
      chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
      chk("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [1:0] sresp;
      logic [3:0] wdly;
      logic [7:0] exp_rdata;
      logic [7:0] exp_err;
      int         exp_w;
   } vec_t;

   initial begin
      vec_t vt [8];
      int   lat;
      vt[0] = '{1'b1, 8'h04, 8'hAB, 2'b00, 4'd0, 8'h00, 8'd0, 1};
      vt[1] = '{1'b0, 8'h04, 8'h00, 2'b00, 4'd0, 8'hAB, 8'd0, 0};
      vt[2] = '{1'b1, 8'h0A, 8'h69, 2'b00, 4'd3, 8'h00, 8'd0, 4};
      vt[3] = '{1'b0, 8'h0A, 8'h00, 2'b00, 4'd0, 8'h69, 8'd0, 0};
      vt[4] = '{1'b1, 8'h20, 8'h11, 2'b10, 4'd0, 8'h00, 8'd1, 1};
      vt[5] = '{1'b1, 8'h21, 8'h22, 2'b10, 4'd0, 8'h00, 8'd2, 1};
      vt[6] = '{1'b0, 8'h04, 8'h00, 2'b11, 4'd0, 8'hAB, 8'd3, 0};
      vt[7] = '{1'b1, 8'h0F, 8'hC3, 2'b00, 4'd0, 8'h00, 8'd3, 1};

      ARESETN = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
      cmd_wdata = 8'h00; rsp_ready = 1'b0;
      repeat (2) @(negedge ACLK);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_valids", {26'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 32'd0);
      chk("rst_addr_data", {8'd0, AWADDR, WDATA, ARADDR}, 32'd0);
      chk("rst_rsp", {21'd0, rsp_write, rsp_resp, rsp_rdata}, 32'd0);
      chk("rst_err", {24'd0, err_count}, 32'd0);
      chk("rst_wstrb", {31'd0, WSTRB}, 32'd1);
      ARESETN = 1'b0;
      @(negedge ACLK);
      chk("cmd_ready_after_release", {31'd0, cmd_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         slv_resp = vt[i].sresp; wdly = vt[i].wdly;
         send_cmd(vt[i].wr, vt[i].addr, vt[i].wdata);
         wait_rsp(lat);
         if (vt[i].wdly == 4'd0) chk("latency", lat, 32'd3);
         chk("rsp_write", {31'd0, rsp_write}, {31'd0, vt[i].wr});
         chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, vt[i].exp_rdata});
         chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, vt[i].sresp});
         if (vt[i].wr) begin
            chk("awaddr", {24'd0, last_awaddr}, {24'd0, vt[i].addr});
            chk("wdata", {24'd0, last_wdata}, {24'd0, vt[i].wdata});
            chk("wstrb", {31'd0, last_wstrb}, 32'd1);
            chk("aw_cycles", aw_cyc, 32'd1);
            chk("w_cycles", w_cyc, vt[i].exp_w);
            chk("bready_early", {31'd0, bready_early}, 32'd0);
         end else begin
            chk("araddr", {24'd0, last_araddr}, {24'd0, vt[i].addr});
         end
         consume();
         chk("err_count", {24'd0, err_count}, {24'd0, vt[i].exp_err});
      end

      // command offered during RD_DATA is ignored; response held under backpressure
      slv_resp = 2'b00; wdly = 4'd0;
      send_cmd(1'b0, 8'h0A, 8'h00);
      @(posedge ACLK);
      #1 begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'hEE; end
      @(posedge ACLK);
      #1 cmd_valid = 1'b0;
      wait_rsp(lat);
      for (int k = 0; k < 5; k++) begin
         chk("rsp_hold", {20'd0, rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {20'd0, 1'b1, 1'b0, 2'b00, 8'h69});
         chk("ignored_cmd", {29'd0, cmd_ready, AWVALID, ARVALID}, 32'd0);
         @(negedge ACLK);
      end
      chk("ignored_awaddr", {24'd0, last_awaddr}, 32'h0F);
      consume();

      // drive err_count into saturation
      slv_resp = 2'b10;
      for (int k = 0; k < 252; k++) begin
         send_cmd(1'b1, 8'h40, 8'h00);
         wait_rsp(lat);
         consume();
      end
      chk("err_at_ff", {24'd0, err_count}, 32'hFF);
      send_cmd(1'b1, 8'h40, 8'h00);
      wait_rsp(lat);
      chk("sat_resp", {30'd0, rsp_resp}, 32'd2);
      consume();
      chk("err_saturated", {24'd0, err_count}, 32'hFF);

      // reset during WR_RESP discards the write
      slv_resp = 2'b00; hold_b = 1'b1;
      send_cmd(1'b1, 8'h30, 8'h77);
      repeat (2) @(negedge ACLK);
      chk("bready_in_wr_resp", {31'd0, BREADY}, 32'd1);
      ARESETN = 1'b1;
      #1;
      chk("midrst_drop", {25'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 32'd0);
      chk("midrst_err", {24'd0, err_count}, 32'd0);
      hold_b = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      ARESETN = 1'b0;
      send_cmd(1'b0, 8'h0F, 8'h00);
      wait_rsp(lat);
      chk("post_rst_latency", lat, 32'd3);
      chk("post_rst_read", {21'd0, rsp_write, rsp_resp, rsp_rdata}, {21'd0, 1'b0, 2'b00, 8'hC3});
      consume();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
